// File: rtl/move_io_sequencer_pkg.sv
// Shared opcode constants and control-step encodings for the move/port sequencer
// and the future full control unit.
package move_io_sequencer_pkg;

  // Encodings are visible on t_state, so values are fixed.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StT0     = 3'd1,
    StT1     = 3'd2,
    StT2     = 3'd3,
    StT3     = 3'd4,
    StHalted = 3'd7
  } step_e;

  localparam int unsigned OpMfhiDef = 5'b11000;
  localparam int unsigned OpMfloDef = 5'b11001;
  localparam int unsigned OpInDef   = 5'b10110;
  localparam int unsigned OpOutDef  = 5'b10111;
  localparam int unsigned OpNopDef  = 5'b11010;
  localparam int unsigned OpHaltDef = 5'b11011;

endpackage

// File: rtl/move_io_sequencer_step_timer.sv
// Per-step hold counter: restarts on step entry, saturates on the step's final cycle.
module move_io_sequencer_step_timer #(
  parameter int unsigned StepHold = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic final_o
);

  localparam int unsigned CntW = $clog2(StepHold) + 1;
  localparam logic [CntW-1:0] Last = CntW'(StepHold - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q != Last) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign final_o = (cnt_q == Last);

endmodule

// File: rtl/move_io_sequencer.sv
// Control-step sequencer: fetch in T0-T2, then T3 execute for mfhi/mflo/in/out/nop/halt.
module move_io_sequencer
  import move_io_sequencer_pkg::*;
#(
  parameter int unsigned OPW       = 5,
  parameter int unsigned STEP_HOLD = 1,
  parameter int unsigned OP_MFHI   = OpMfhiDef,
  parameter int unsigned OP_MFLO   = OpMfloDef,
  parameter int unsigned OP_IN     = OpInDef,
  parameter int unsigned OP_OUT    = OpOutDef,
  parameter int unsigned OP_NOP    = OpNopDef,
  parameter int unsigned OP_HALT   = OpHaltDef
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic [OPW-1:0] opcode_in,
  input  logic           mem_rdy,
  output logic           PCout,
  output logic           ZLowOut,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           InPortOut,
  output logic           Gra,
  output logic           Rout,
  output logic           MARin,
  output logic           Zin,
  output logic           incPC,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Rin,
  output logic           OutPortIn,
  output logic           read,
  output logic [2:0]     t_state,
  output logic           done,
  output logic           illegal,
  output logic           halted
);

  localparam logic [OPW-1:0] OpMfhi = OPW'(OP_MFHI);
  localparam logic [OPW-1:0] OpMflo = OPW'(OP_MFLO);
  localparam logic [OPW-1:0] OpIn   = OPW'(OP_IN);
  localparam logic [OPW-1:0] OpOut  = OPW'(OP_OUT);
  localparam logic [OPW-1:0] OpNop  = OPW'(OP_NOP);
  localparam logic [OPW-1:0] OpHalt = OPW'(OP_HALT);

  step_e state_q, state_d;
  logic  step_final;
  logic  restart;

  logic is_mfhi, is_mflo, is_in, is_out, is_nop, is_halt;

  assign is_mfhi = (opcode_in == OpMfhi);
  assign is_mflo = (opcode_in == OpMflo);
  assign is_in   = (opcode_in == OpIn);
  assign is_out  = (opcode_in == OpOut);
  assign is_nop  = (opcode_in == OpNop);
  assign is_halt = (opcode_in == OpHalt);

  // Any state change is a step entry, including T3 -> T0 back-to-back.
  assign restart = (state_d != state_q);

  move_io_sequencer_step_timer #(
    .StepHold(STEP_HOLD)
  ) u_step_timer (
    .clk_i    (clk),
    .rst_ni   (clr),
    .restart_i(restart),
    .final_o  (step_final)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Drive/select controls follow the state for the whole step; load strobes
  // fire only in the step's final cycle.
  always_comb begin
    state_d   = state_q;
    PCout     = 1'b0;
    ZLowOut   = 1'b0;
    MDRout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    InPortOut = 1'b0;
    Gra       = 1'b0;
    Rout      = 1'b0;
    MARin     = 1'b0;
    Zin       = 1'b0;
    incPC     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Rin       = 1'b0;
    OutPortIn = 1'b0;
    read      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StT0;
      end
      StT0: begin
        PCout = 1'b1;
        if (step_final) begin
          MARin   = 1'b1;
          incPC   = 1'b1;
          Zin     = 1'b1;
          state_d = StT1;
        end
      end
      StT1: begin
        ZLowOut = 1'b1;
        read    = 1'b1;
        // Memory wait stretches the step; the counter sits saturated meanwhile.
        if (step_final && mem_rdy) begin
          PCin    = 1'b1;
          MDRin   = 1'b1;
          state_d = StT2;
        end
      end
      StT2: begin
        MDRout = 1'b1;
        if (step_final) begin
          IRin    = 1'b1;
          state_d = StT3;
        end
      end
      StT3: begin
        if (is_mfhi) begin
          HIout = 1'b1;
          Gra   = 1'b1;
          Rin   = step_final;
        end else if (is_mflo) begin
          LOout = 1'b1;
          Gra   = 1'b1;
          Rin   = step_final;
        end else if (is_in) begin
          InPortOut = 1'b1;
          Gra       = 1'b1;
          Rin       = step_final;
        end else if (is_out) begin
          Rout      = 1'b1;
          Gra       = 1'b1;
          OutPortIn = step_final;
        end else if (!is_nop && !is_halt) begin
          illegal = step_final;
        end

        if (step_final) begin
          if (is_halt) begin
            state_d = StHalted;
          end else begin
            done    = 1'b1;
            state_d = run ? StT0 : StIdle;
          end
        end
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign t_state = state_q;

endmodule
